mips_alu_datapath: RTL and testbench



---
 rtl/mips_pkg.sv | 34 +++
 rtl/mips_alu_core.sv | 55 +++++
 rtl/mips_alu_datapath.sv | 76 +++++++
 tb/tb_mips_alu_datapath.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared constants for the single-cycle MIPS execute stage: ALU-control codes,
// main-control alu_op encodings, R-type funct codes and the default reset PC.
package mips_pkg;

  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } alu_ctrl_e;

  // alu_op 11 is not produced by main control today but decodes as subtract
  typedef enum logic [1:0] {
    ALUOP_ADD     = 2'b00,
    ALUOP_SUB     = 2'b01,
    ALUOP_RTYPE   = 2'b10,
    ALUOP_SUB_ALT = 2'b11
  } alu_op_e;

  localparam logic [3:0] FUNCT_ADD = 4'b0000;
  localparam logic [3:0] FUNCT_SUB = 4'b0010;
  localparam logic [3:0] FUNCT_AND = 4'b0100;
  localparam logic [3:0] FUNCT_OR  = 4'b0101;
  localparam logic [3:0] FUNCT_SLT = 4'b1010;

  localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_0000;

  function automatic logic sub_overflow(input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] diff);
    return (a[31] != b[31]) && (diff[31] != a[31]);
  endfunction

endpackage

// File: rtl/mips_alu_core.sv
// Combinational 32-bit ALU with zero flag; the overflow output exists only
// when ALU_OVERFLOW_EN is defined.
module mips_alu_core
  import mips_pkg::*;
(
  input  logic [2:0]  alu_ctrl,
  input  logic [31:0] a,
  input  logic [31:0] b,
`ifdef ALU_OVERFLOW_EN
  output logic        overflow,
`endif
  output logic [31:0] result,
  output logic        zero
);

  logic [31:0] sum;
  logic [31:0] diff;
  logic        ovf_sub;
  logic        less;

  assign sum     = a + b;
  assign diff    = a - b;
  assign ovf_sub = sub_overflow(a, b, diff);
  // Sign of the difference corrected by overflow gives a true signed compare
  assign less    = diff[31] ^ ovf_sub;

  always_comb begin
    result = 32'h0000_0000;
    case (alu_ctrl)
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_ADD: result = sum;
      ALU_SUB: result = diff;
      ALU_SLT: result = {31'b0, less};
      default: result = 32'h0000_0000;
    endcase
  end

  assign zero = (result == 32'h0000_0000);

`ifdef ALU_OVERFLOW_EN
  logic ovf_add;
  assign ovf_add = (a[31] == b[31]) && (sum[31] != a[31]);

  always_comb begin
    overflow = 1'b0;
    case (alu_ctrl)
      ALU_ADD: overflow = ovf_add;
      ALU_SUB: overflow = ovf_sub;
      default: overflow = 1'b0;
    endcase
  end
`endif

endmodule

// File: rtl/mips_alu_datapath.sv
// Execute-stage core: ALU-control decode, ALU, PC adders and the PC register.
// Define ALU_OVERFLOW_EN to add the signed-overflow output.
module mips_alu_datapath
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = PC_RESET_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  alu_op,
  input  logic [5:0]  funct,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        branch,
  input  logic [31:0] branch_offset,
  output logic [2:0]  alu_ctrl,
  output logic [31:0] alu_result,
  output logic        zero,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
`ifdef ALU_OVERFLOW_EN
  output logic        overflow,
`endif
  output logic [31:0] branch_target
);

  logic [31:0] pc_next;
  logic        unused_funct_hi;

  // Only funct[3:0] distinguishes the supported R-type operations
  assign unused_funct_hi = ^funct[5:4];

  always_comb begin
    alu_ctrl = ALU_ADD;
    case (alu_op)
      ALUOP_ADD:               alu_ctrl = ALU_ADD;
      ALUOP_SUB, ALUOP_SUB_ALT: alu_ctrl = ALU_SUB;
      ALUOP_RTYPE: begin
        case (funct[3:0])
          FUNCT_ADD: alu_ctrl = ALU_ADD;
          FUNCT_SUB: alu_ctrl = ALU_SUB;
          FUNCT_AND: alu_ctrl = ALU_AND;
          FUNCT_OR:  alu_ctrl = ALU_OR;
          FUNCT_SLT: alu_ctrl = ALU_SLT;
          default:   alu_ctrl = ALU_ADD;
        endcase
      end
      default: alu_ctrl = ALU_ADD;
    endcase
  end

  mips_alu_core u_alu_core (
    .alu_ctrl (alu_ctrl),
    .a        (src_a),
    .b        (src_b),
`ifdef ALU_OVERFLOW_EN
    .overflow (overflow),
`endif
    .result   (alu_result),
    .zero     (zero)
  );

  // The word-offset shift discards branch_offset[31:30]; all adds wrap
  assign pc_plus4      = pc + 32'd4;
  assign branch_target = pc_plus4 + (branch_offset << 2);
  assign pc_next       = (branch && zero) ? branch_target : pc_plus4;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else begin
      pc <= pc_next;
    end
  end

endmodule

// File: tb/tb_mips_alu_datapath.sv
// Directed self-checking bench for mips_alu_datapath; overflow checks are
// compiled in only when ALU_OVERFLOW_EN is defined.
module tb_mips_alu_datapath;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  alu_op;
  logic [5:0]  funct;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        branch;
  logic [31:0] branch_offset;
  logic [2:0]  alu_ctrl;
  logic [31:0] alu_result;
  logic        zero;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] branch_target;
`ifdef ALU_OVERFLOW_EN
  logic        overflow;
`endif

  int tests    = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mips_alu_datapath dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .alu_op        (alu_op),
    .funct         (funct),
    .src_a         (src_a),
    .src_b         (src_b),
    .branch        (branch),
    .branch_offset (branch_offset),
    .alu_ctrl      (alu_ctrl),
    .alu_result    (alu_result),
    .zero          (zero),
    .pc            (pc),
    .pc_plus4      (pc_plus4),
`ifdef ALU_OVERFLOW_EN
    .overflow      (overflow),
`endif
    .branch_target (branch_target)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic [1:0] op, input logic [5:0] fn,
                                input logic [31:0] a, input logic [31:0] b);
    alu_op = op;
    funct  = fn;
    src_a  = a;
    src_b  = b;
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    tests++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  initial begin
    // Reset held with a taken-branch condition present
    rst_n = 1'b0;
    branch = 1'b1;
    branch_offset = 32'h0000_0003;
    apply_stimulus(2'b01, 6'h00, 32'd5, 32'd5);
    tick();
    tick();
    check_output("reset_pc", pc, 32'h0);
    check_output("reset_zero", {31'b0, zero}, 32'd1);

    branch = 1'b0;
    rst_n  = 1'b1;
    tick();
    check_output("pc_step4", pc, 32'd4);
    tick();
    check_output("pc_step8", pc, 32'd8);
    tick();
    check_output("pc_step12", pc, 32'd12);

    // R-type decode
    apply_stimulus(2'b10, 6'h20, 32'h0000_00F0, 32'h0000_0F0F);
    check_output("rt_add_ctrl", {29'b0, alu_ctrl}, 32'd2);
    check_output("rt_add_res", alu_result, 32'h0000_0FFF);
    apply_stimulus(2'b10, 6'h22, 32'h0000_00F0, 32'h0000_0F0F);
    check_output("rt_sub_ctrl", {29'b0, alu_ctrl}, 32'd6);
    check_output("rt_sub_res", alu_result, 32'hFFFF_F1E1);
    apply_stimulus(2'b10, 6'h24, 32'h0000_00F0, 32'h0000_0F0F);
    check_output("rt_and_ctrl", {29'b0, alu_ctrl}, 32'd0);
    check_output("rt_and_res", alu_result, 32'h0);
    check_output("rt_and_zero", {31'b0, zero}, 32'd1);
    apply_stimulus(2'b10, 6'h25, 32'h0000_00F0, 32'h0000_0F0F);
    check_output("rt_or_ctrl", {29'b0, alu_ctrl}, 32'd1);
    check_output("rt_or_res", alu_result, 32'h0000_0FFF);
    check_output("rt_or_zero", {31'b0, zero}, 32'd0);
    apply_stimulus(2'b10, 6'h2A, 32'h0000_00F0, 32'h0000_0F0F);
    check_output("rt_slt_ctrl", {29'b0, alu_ctrl}, 32'd7);
    check_output("rt_slt_res", alu_result, 32'd1);
    apply_stimulus(2'b10, 6'h27, 32'h0000_00F0, 32'h0000_0F0F);
    check_output("rt_unknown_ctrl", {29'b0, alu_ctrl}, 32'd2);
    apply_stimulus(2'b00, 6'h22, 32'h0000_00F0, 32'h0000_0F0F);
    check_output("op00_ctrl", {29'b0, alu_ctrl}, 32'd2);
    apply_stimulus(2'b11, 6'h20, 32'h0000_00F0, 32'h0000_0F0F);
    check_output("op11_ctrl", {29'b0, alu_ctrl}, 32'd6);

    // Signed slt across the sign boundary
    apply_stimulus(2'b10, 6'h2A, 32'hFFFF_FFFF, 32'h0000_0001);
    check_output("slt_neg1_lt_1", alu_result, 32'd1);
    apply_stimulus(2'b10, 6'h2A, 32'h7FFF_FFFF, 32'h8000_0000);
    check_output("slt_max_lt_min", alu_result, 32'd0);
    check_output("slt_zero", {31'b0, zero}, 32'd1);

    // Wrapping add and sub results
    apply_stimulus(2'b00, 6'h00, 32'h7FFF_FFFF, 32'h0000_0001);
    check_output("add_wrap_res", alu_result, 32'h8000_0000);
`ifdef ALU_OVERFLOW_EN
    check_output("add_ovf", {31'b0, overflow}, 32'd1);
`endif
    apply_stimulus(2'b01, 6'h00, 32'h8000_0000, 32'h0000_0001);
    check_output("sub_wrap_res", alu_result, 32'h7FFF_FFFF);
`ifdef ALU_OVERFLOW_EN
    check_output("sub_ovf", {31'b0, overflow}, 32'd1);
`endif
    apply_stimulus(2'b00, 6'h00, 32'h0000_0001, 32'h0000_0001);
    check_output("add_small_res", alu_result, 32'd2);
`ifdef ALU_OVERFLOW_EN
    check_output("add_no_ovf", {31'b0, overflow}, 32'd0);
    apply_stimulus(2'b10, 6'h24, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check_output("and_no_ovf", {31'b0, overflow}, 32'd0);
`endif

    // Branch not taken from pc = 8
    rst_n = 1'b0;
    tick();
    check_output("rst2_pc", pc, 32'h0);
    rst_n = 1'b1;
    tick();
    tick();
    check_output("pc_at8_a", pc, 32'd8);
    branch = 1'b1;
    branch_offset = 32'h0000_0003;
    apply_stimulus(2'b01, 6'h00, 32'd5, 32'd6);
    check_output("nt_zero", {31'b0, zero}, 32'd0);
    check_output("nt_pc_plus4", pc_plus4, 32'h0000_000C);
    check_output("nt_target", branch_target, 32'h0000_0018);
    tick();
    check_output("nt_pc", pc, 32'h0000_000C);

    // Branch taken from pc = 8
    rst_n  = 1'b0;
    branch = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    check_output("pc_at8_b", pc, 32'd8);
    branch = 1'b1;
    apply_stimulus(2'b01, 6'h00, 32'd5, 32'd5);
    check_output("tk_zero", {31'b0, zero}, 32'd1);
    check_output("tk_target", branch_target, 32'h0000_0018);
    tick();
    check_output("tk_pc", pc, 32'h0000_0018);

    // Negative offsets: back to 0x10, then self-branch holds
    branch_offset = 32'hFFFF_FFFD;
    tick();
    check_output("neg3_pc", pc, 32'h0000_0010);
    branch_offset = 32'hFFFF_FFFF;
    #1;
    check_output("self_target", branch_target, 32'h0000_0010);
    tick();
    check_output("self_pc1", pc, 32'h0000_0010);
    tick();
    check_output("self_pc2", pc, 32'h0000_0010);

    // Jump to the top of the address space, then wrap to 0
    branch_offset = 32'hFFFF_FFFA;
    tick();
    check_output("top_pc", pc, 32'hFFFF_FFFC);
    check_output("top_pc_plus4", pc_plus4, 32'h0);
    branch = 1'b0;
    tick();
    check_output("wrap_pc", pc, 32'h0);

    // Mid-stream reset overrides a taken branch
    tick();
    check_output("pre_rst_pc", pc, 32'd4);
    branch = 1'b1;
    branch_offset = 32'h0000_0010;
    rst_n = 1'b0;
    tick();
    check_output("rst_override_pc", pc, 32'h0);
    rst_n = 1'b1;
    tick();
    check_output("post_rst_branch_pc", pc, 32'h0000_0044);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
